// File: rtl/note_sequencer_if.sv
// Host-side bus of the note sequencer: buffer write port, playback control
// and the outputs that feed the square-wave generator.
interface note_sequencer_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_freq;
    logic [15:0]       wr_dur;
    logic [ADDR_W:0]   seq_len;
    logic              loop_en;
    logic              start;
    logic              stop;
    logic [15:0]       freq_hz;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] note_idx;
    logic              note_strobe;

    modport master (
        output wr_en, wr_addr, wr_freq, wr_dur, seq_len, loop_en, start, stop,
        input  freq_hz, busy, done, note_idx, note_strobe
    );

    modport slave (
        input  wr_en, wr_addr, wr_freq, wr_dur, seq_len, loop_en, start, stop,
        output freq_hz, busy, done, note_idx, note_strobe
    );
endinterface

// File: rtl/note_sequencer.sv
// Steps through a buffer of (freq, dur) entries with ms-accurate durations,
// optional silent gaps and looping, driving the square-wave generator's freq_hz.
module note_sequencer #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned GAP_MS = 10
) (
    input  logic            clk,
    input  logic            reset,
    note_sequencer_if.slave bus
);
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned TICK    = CLK_HZ / 1000;
    localparam int unsigned PRE_W   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam bit          HAS_GAP = (GAP_MS != 0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_PLAY = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef struct packed {
        logic [15:0] freq;
        logic [15:0] dur;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            rd_entry;
    logic [2:0]        state_q, state_d;
    logic [15:0]       freq_q, freq_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d, len_clamped;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [15:0]       ms_q, ms_d;
    logic              busy_q;
    logic              done_q, done_d;
    logic              strobe_q, strobe_d;
    logic              tick, end_step, seq_end;

    // Note buffer: no reset, writes accepted in any state
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= '{freq: bus.wr_freq, dur: bus.wr_dur};
        end
    end

    always_comb begin
        rd_entry    = mem_q[idx_q];
        len_clamped = (bus.seq_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.seq_len;
        tick        = (pre_q == PRE_W'(TICK - 1));
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        idx_d    = idx_q;
        len_d    = len_q;
        pre_d    = pre_q;
        ms_d     = ms_q;
        done_d   = 1'b0;
        strobe_d = 1'b0;
        end_step = 1'b0;
        seq_end  = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

        case (state_q)
            S_IDLE: begin
                freq_d = 16'd0;
                if (bus.start && (len_clamped != '0)) begin
                    len_d   = len_clamped;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (rd_entry.dur == 16'd0) begin
                    end_step = 1'b1;
                    seq_end  = 1'b1;
                end else begin
                    state_d  = S_PLAY;
                    freq_d   = rd_entry.freq;
                    strobe_d = 1'b1;
                    pre_d    = '0;
                    ms_d     = rd_entry.dur;
                end
            end
            S_PLAY, S_GAP: begin
                pre_d = tick ? '0 : pre_q + PRE_W'(1);
                if (tick) begin
                    ms_d = ms_q - 16'd1;
                    if (ms_q == 16'd1) begin
                        if ((state_q == S_PLAY) && HAS_GAP) begin
                            state_d = S_GAP;
                            freq_d  = 16'd0;
                            ms_d    = 16'(GAP_MS);
                        end else begin
                            end_step = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                freq_d  = 16'd0;
                state_d = S_IDLE;
            end
            default: begin
                freq_d  = 16'd0;
                state_d = S_IDLE;
            end
        endcase

        // End of a note: advance, wrap around when looping, or finish
        if (end_step) begin
            if (seq_end) begin
                if (bus.loop_en) begin
                    idx_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    freq_d  = 16'd0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end else begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = S_LOAD;
            end
        end

        if (bus.stop && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            freq_d   = 16'd0;
            idx_d    = idx_q;
            done_d   = 1'b0;
            strobe_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            freq_q   <= 16'd0;
            idx_q    <= '0;
            len_q    <= '0;
            pre_q    <= '0;
            ms_q     <= 16'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            pre_q    <= pre_d;
            ms_q     <= ms_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= done_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.freq_hz     = freq_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.note_idx    = idx_q;
    assign bus.note_strobe = strobe_q;
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays a programmed melody by driving the `freq_hz` input of the square-wave generator. The melody is a list of (frequency, duration) entries held in a small internal note buffer. A host writes the buffer, sets a length and pulses `start`. The block then steps through the entries with millisecond-accurate durations, an optional silent gap between notes, and optional looping. It sits between the control logic (keys/switches or a host FSM) and the generator on the 50 MHz system clock.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; ms tick = CLK_HZ/1000 cycles (TICK).
- `ADDR_W`, 4, buffer address width; DEPTH = 2**ADDR_W entries.
- `GAP_MS`, 10, silent gap inserted after every note, in ms; 0 disables the gap.

- `clk`, in, 1, system clock; all logic on the rising edge.
- `reset`, in, 1, synchronous, active-high reset.
- `wr_en`, in, 1, writes one buffer entry this cycle.
- `wr_addr`, in, ADDR_W, entry index to write.
- `wr_freq`, in, 16, note frequency in Hz; 0 = rest (silence).
- `wr_dur`, in, 16, note duration in ms; 0 = end-of-sequence marker.
- `seq_len`, in, ADDR_W+1, number of entries to play; sampled on accepted `start`; values above DEPTH are clamped to DEPTH.
- `loop_en`, in, 1, sampled continuously; when 1 at sequence end, playback restarts at entry 0.
- `start`, in, 1, single-cycle pulse; begins playback from entry 0.
- `stop`, in, 1, single-cycle pulse; aborts playback.
- `freq_hz`, out, 16, frequency to the square-wave generator; registered.
- `busy`, out, 1, high from the cycle after an accepted start until return to IDLE.
- `done`, out, 1, one-cycle pulse on normal completion.
- `note_idx`, out, ADDR_W, index of the entry currently loaded or playing.
- `note_strobe`, out, 1, one-cycle pulse in the cycle `freq_hz` takes a new entry's value.

## Operation
- Buffer: DEPTH x 32 bits, holding {freq, dur}.
  - One write port; synchronous read in the LOAD state.
  - Buffer contents are not reset.
  - Writes are accepted in any state. A write to the entry currently playing takes effect only the next time that entry is loaded.
- States: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE:
  - Outputs: `freq_hz`=0, `busy`=0.
  - `start` with clamped `seq_len`≠0: latch the length, set `note_idx`=0, go to LOAD.
  - `start` with `seq_len`=0 is ignored; no `done` pulse.
- LOAD (1 cycle):
  - Reads entry `note_idx`. `freq_hz` keeps its previous value during this cycle.
  - If the entry's dur=0: treat it as end of sequence (go to the end-of-sequence step below) without touching `freq_hz`.
  - Otherwise go to PLAY. On entry: `freq_hz`=entry freq, `note_strobe`=1, ms prescaler cleared, ms-remaining counter = dur.
- PLAY:
  - Prescaler counts 0..TICK-1. Each wrap decrements ms-remaining.
  - When ms-remaining decrements to 0, the next state is GAP if GAP_MS>0, otherwise the end-of-sequence step.
- GAP: `freq_hz`=0 for GAP_MS ms using the same prescaler, then the end-of-sequence step.
- End-of-sequence step:
  - If `note_idx` = len-1 (or a dur=0 marker was hit): go to LOAD with `note_idx`=0 if `loop_en`=1, otherwise go to DONE.
  - Otherwise `note_idx`+1 and go to LOAD.
- DONE (1 cycle): `freq_hz`=0, `done`=1, then IDLE with `busy`=0.
- `stop` in any non-IDLE state: next cycle is IDLE, `freq_hz`=0, `busy`=0, no `done` pulse, `note_idx` held.
- Priorities:
  - `start` while busy is ignored.
  - `stop` and `start` in the same cycle: `stop` wins.
  - `reset` overrides everything.
- Width rules: ms-remaining counter is 16 bits; prescaler is wide enough for TICK-1 ($clog2(CLK_HZ/1000)).

## Timing
- Reset values: `freq_hz`=0, `busy`=0, `done`=0, `note_idx`=0, `note_strobe`=0, state IDLE.
- Start latency: `start` at cycle S → LOAD at S+1 (`busy`=1) → `freq_hz`/`note_strobe` update at S+2.
- Note length: `freq_hz` holds a note's value for exactly dur×TICK cycles in PLAY, plus 1 LOAD cycle of the following entry when GAP_MS=0.
- Gap length: `freq_hz`=0 for GAP_MS×TICK cycles plus 1 LOAD cycle.
- Completion: after the final PLAY/GAP cycle, `done` is high in the next cycle and `busy` drops one cycle after that.
- Reset asserted mid-playback: all outputs return to their reset values in the next cycle.

## Test plan
- CLK_HZ=4000 (TICK=4), GAP_MS=0, entries {440,2},{880,1}, len=2, start → `freq_hz`=440 for 9 cycles (8 PLAY + 1 LOAD), then 880 for 4 cycles, then 0. `done` pulses once; `note_strobe` pulses twice.
- Same setup with GAP_MS=1 → sequence 440 (8 cycles), 0 (5 cycles), 880 (4 cycles), 0; `done` asserted.
- `loop_en`=1, len=2 → after entry 1, `note_idx` returns to 0 and 440 replays with no `done` pulse. Deassert `loop_en` → `done` after the next pass.
- Entry 1 dur=0, len=4 → only entry 0 plays, then `done`; `note_idx` never exceeds 1.
- `stop` mid-note, and `stop`+`start` in the same cycle → `freq_hz`=0 and `busy`=0 next cycle, no `done`. `start` with `seq_len`=0 → no state change.
- `reset` asserted during PLAY → all outputs 0 next cycle. Writing entry 0 while it plays changes its freq only on the next loop.
